eth_rx_buf_ctrl: RTL and testbench
==================================

Name: eth_rx_buf_ctrl

Overview:
- Packet-buffer controller between the RMII receive control/byte path and the downstream consumer (MAC filter / UDP parser).
- Writes received frame bytes into an external simple dual-port byte RAM and strips the 4 FCS bytes.
- Commits a frame only on good-CRC status; otherwise rewinds the write pointer. Committed frames are streamed out over a valid/ready byte interface with a last flag.

Parameters:
- pADDR_W, 11, RAM address width; buffer holds 2^pADDR_W bytes.
- pDESC_DEPTH, 4, committed-frame length FIFO depth (power of 2).
- pMIN_BYTES, 64, minimum frame size including FCS.
- pMAX_BYTES, 1518, maximum frame size including FCS.
- pSTATUS_TO, 8, cycles allowed from Rx_Eop to status before the frame is dropped.

Ports:
- Clk  in  1  system clock (50 MHz RMII domain)
- Rst  in  1  synchronous, active-high reset
- Rx_Byte_Vld  in  1  one-cycle strobe: Rx_Byte valid
- Rx_Byte  in  8  received byte, destination address first
- Rx_Eop  in  1  coincident with the last byte strobe of the frame
- Rx_Good  in  1  one-cycle pulse: CRC and EtherType correct
- Rx_Bad  in  1  one-cycle pulse: frame invalid
- Wr_En  out  1  RAM write strobe
- Wr_Addr  out  pADDR_W  RAM write address
- Wr_Data  out  8  RAM write data
- Rd_En  out  1  RAM read strobe
- Rd_Addr  out  pADDR_W  RAM read address
- Rd_Data  in  8  RAM read data, valid the cycle after Rd_En
- M_Data  out  8  output byte
- M_Valid  out  1  output valid
- M_Last  out  1  last payload byte of frame (FCS excluded)
- M_Ready  in  1  downstream ready
- Good_Cnt  out  16  committed frames, saturating
- Drop_Cnt  out  16  dropped frames (bad, runt, giant, overflow, no descriptor, timeout), saturating

Behaviour:
- Reset:
  - All outputs are 0.
  - Wr_Ptr, Commit_Ptr and Rd_Ptr (pADDR_W+1 bits) are 0.
  - Descriptor FIFO is empty; both FSMs are idle.
- Write FSM states:
  - W_IDLE:
    - Rx_Byte_Vld with descriptor FIFO not full: write byte, count=1, go to W_STORE.
    - Rx_Byte_Vld with descriptor FIFO full: go to W_DROP.
  - W_STORE:
    - Each Rx_Byte_Vld: Wr_En=1, Wr_Addr=Wr_Ptr[pADDR_W-1:0], Wr_Data=Rx_Byte (registered, asserted the cycle after the strobe), Wr_Ptr++ and count++.
    - Byte arriving when Wr_Ptr-Rd_Ptr == 2^pADDR_W: not written; go to W_DROP.
    - count exceeds pMAX_BYTES: go to W_DROP.
    - Rx_Eop (with its byte): go to W_STATUS.
  - W_STATUS:
    - Rx_Good with pMIN_BYTES <= count <= pMAX_BYTES:
      - push length count-4 into the descriptor FIFO;
      - Commit_Ptr = Commit_Ptr + count - 4;
      - Wr_Ptr = new Commit_Ptr (FCS bytes discarded);
      - Good_Cnt++; go to W_IDLE.
    - Rx_Bad, Rx_Good and Rx_Bad together, runt, or pSTATUS_TO cycles with no status: Wr_Ptr=Commit_Ptr, Drop_Cnt++, go to W_IDLE.
  - W_DROP:
    - Ignore bytes; Wr_Ptr=Commit_Ptr.
    - On Rx_Good, Rx_Bad or timeout after Rx_Eop: Drop_Cnt++, go to W_IDLE.
- Read FSM states:
  - R_IDLE:
    - Descriptor FIFO not empty: pop the length into a remaining-byte counter, go to R_STREAM.
  - R_STREAM:
    - Issue Rd_En/Rd_Addr=Rd_Ptr and Rd_Ptr++ whenever the 2-entry output skid buffer will have room.
    - Sustain 1 byte/cycle while M_Ready=1.
    - First M_Valid within 3 cycles of the descriptor becoming available.
    - M_Last is asserted on the final byte.
    - When the final byte is accepted (M_Valid & M_Ready & M_Last), go to R_IDLE.
  - M_Data/M_Valid/M_Last stay stable while M_Valid=1 and M_Ready=0.
- Pointer arithmetic:
  - Pointers are pADDR_W+1 bits and wrap modulo 2^(pADDR_W+1); RAM address is the lower pADDR_W bits.
  - Occupancy = Wr_Ptr - Rd_Ptr.
  - The read side frees space byte by byte as it reads, so a frame may straddle the wrap point.
- Simultaneous events:
  - Descriptor push and pop in the same cycle are both honoured.
  - A commit in the same cycle a new frame's first byte arrives is not possible (the FSM is in W_STATUS); any Rx_Byte_Vld in W_STATUS is ignored.
- Counters: Good_Cnt and Drop_Cnt saturate at 16'hFFFF.
- Mid-operation reset: an in-progress frame is discarded and an in-progress output frame is aborted without M_Last.

Test Plan:
- 64-byte frame + Rx_Good, M_Ready=1 -> 60 bytes out in order; M_Last on byte 60; Good_Cnt=1; Commit_Ptr=60.
- 100-byte frame + Rx_Bad, then 70-byte good frame -> only 66 bytes out; Drop_Cnt=1; second frame data starts at address 0.
- 40-byte frame + Rx_Good -> runt drop; no output; Drop_Cnt=1. Separately, a 1519-byte frame -> giant drop.
- pADDR_W=8, M_Ready=0: a 200-byte good frame, then a 100-byte frame -> second dropped on overflow. Then M_Ready=1 -> 196 bytes out; a following 100-byte frame commits across the wrap at address 255->0.
- 5 back-to-back 64-byte good frames with M_Ready=0 -> 5th dropped (descriptor FIFO full); with M_Ready=1 the first 4 frames stream out correctly.
- M_Ready toggling 1010... during a 64-byte frame -> no byte lost or duplicated; data held stable while stalled. Rx_Eop with no status for 8 cycles -> timeout drop.

Source files
------------

// File: rtl/eth_rx_buf_ctrl.sv
// Receive packet-buffer controller: stores RMII frames into a byte RAM, commits on good
// CRC (FCS stripped) or rewinds, and streams committed frames out over valid/ready.
`timescale 1ns/1ps
module eth_rx_buf_ctrl #(
  parameter int pADDR_W     = 11,
  parameter int pDESC_DEPTH = 4,
  parameter int pMIN_BYTES  = 64,
  parameter int pMAX_BYTES  = 1518,
  parameter int pSTATUS_TO  = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Rx_Byte_Vld,
  input  logic [7:0]         Rx_Byte,
  input  logic               Rx_Eop,
  input  logic               Rx_Good,
  input  logic               Rx_Bad,
  output logic               Wr_En,
  output logic [pADDR_W-1:0] Wr_Addr,
  output logic [7:0]         Wr_Data,
  output logic               Rd_En,
  output logic [pADDR_W-1:0] Rd_Addr,
  input  logic [7:0]         Rd_Data,
  output logic [7:0]         M_Data,
  output logic               M_Valid,
  output logic               M_Last,
  input  logic               M_Ready,
  output logic [15:0]        Good_Cnt,
  output logic [15:0]        Drop_Cnt
);
  localparam int PW = pADDR_W + 1;
  localparam int CW = $clog2(pMAX_BYTES + 2);
  localparam int DW = $clog2(pDESC_DEPTH);
  localparam int TW = $clog2(pSTATUS_TO + 1);
  localparam logic [PW-1:0] BUF_BYTES = {1'b1, {pADDR_W{1'b0}}};

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_STATUS, W_DROP} wstate_e;
  typedef enum logic {R_IDLE, R_STREAM} rstate_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  wstate_e       wst_q;
  rstate_e       rst_q;
  logic [PW-1:0] wr_ptr_q, commit_ptr_q, rd_ptr_q, commit_nxt;
  logic [CW-1:0] cnt_q, rem_q, head_len;
  logic [TW-1:0] to_q;
  logic          eop_seen_q;
  logic [CW-1:0] desc_mem [pDESC_DEPTH];
  logic [DW:0]   desc_wp_q, desc_rp_q;
  logic          desc_full, desc_empty, buf_full, len_ok, commit_ok, status_to;
  logic          infl_q, infl_last_q, pop_out, issue, issue_last;
  logic [1:0]    sk_cnt_q, sk_cnt_d;
  logic [8:0]    sk0_q, sk0_d, sk1_q, sk1_d;
  logic [2:0]    fill_nxt;

  assign desc_full  = (desc_wp_q - desc_rp_q) == (DW+1)'(pDESC_DEPTH);
  assign desc_empty = desc_wp_q == desc_rp_q;
  assign buf_full   = (wr_ptr_q - rd_ptr_q) == BUF_BYTES;
  assign len_ok     = (cnt_q >= CW'(pMIN_BYTES)) && (cnt_q <= CW'(pMAX_BYTES));
  assign commit_ok  = (wst_q == W_STATUS) && Rx_Good && !Rx_Bad && len_ok;
  assign status_to  = to_q == TW'(pSTATUS_TO - 1);
  assign commit_nxt = commit_ptr_q + PW'(cnt_q - CW'(4));

  // Write side: byte capture, commit/rewind, counters
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wst_q        <= W_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      eop_seen_q   <= 1'b0;
      desc_wp_q    <= '0;
      Wr_En        <= 1'b0;
      Wr_Addr      <= '0;
      Wr_Data      <= '0;
      Good_Cnt     <= '0;
      Drop_Cnt     <= '0;
    end else begin
      Wr_En <= 1'b0;
      case (wst_q)
        W_IDLE, W_STORE: begin
          if (Rx_Byte_Vld) begin
            if (buf_full || desc_full && wst_q == W_IDLE ||
                wst_q == W_STORE && cnt_q == CW'(pMAX_BYTES)) begin
              wst_q      <= W_DROP;
              wr_ptr_q   <= commit_ptr_q;
              eop_seen_q <= Rx_Eop;
              to_q       <= '0;
            end else begin
              Wr_En    <= 1'b1;
              Wr_Addr  <= wr_ptr_q[pADDR_W-1:0];
              Wr_Data  <= Rx_Byte;
              wr_ptr_q <= wr_ptr_q + PW'(1);
              cnt_q    <= (wst_q == W_IDLE) ? CW'(1) : cnt_q + CW'(1);
              to_q     <= '0;
              wst_q    <= Rx_Eop ? W_STATUS : W_STORE;
            end
          end
        end
        W_STATUS: begin
          if (commit_ok) begin
            commit_ptr_q <= commit_nxt;
            wr_ptr_q     <= commit_nxt;
            desc_wp_q    <= desc_wp_q + (DW+1)'(1);
            Good_Cnt     <= sat_inc(Good_Cnt);
            wst_q        <= W_IDLE;
          end else if (Rx_Good || Rx_Bad || status_to) begin
            wr_ptr_q <= commit_ptr_q;
            Drop_Cnt <= sat_inc(Drop_Cnt);
            wst_q    <= W_IDLE;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        default: begin
          wr_ptr_q <= commit_ptr_q;
          if (Rx_Byte_Vld && Rx_Eop) eop_seen_q <= 1'b1;
          if (Rx_Good || Rx_Bad || (eop_seen_q && status_to)) begin
            Drop_Cnt <= sat_inc(Drop_Cnt);
            wst_q    <= W_IDLE;
          end else if (eop_seen_q) begin
            to_q <= to_q + TW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (commit_ok) desc_mem[desc_wp_q[DW-1:0]] <= cnt_q - CW'(4);
  end

  // Read side: issue a read only if the skid buffer can absorb its data next cycle
  assign head_len   = desc_mem[desc_rp_q[DW-1:0]];
  assign pop_out    = M_Valid && M_Ready;
  assign fill_nxt   = {1'b0, sk_cnt_q} + {2'b0, infl_q} - {2'b0, pop_out};
  assign issue      = !Rst && ((rst_q == R_IDLE && !desc_empty) ||
                               (rst_q == R_STREAM && rem_q != '0 && fill_nxt <= 3'd1));
  assign issue_last = (rst_q == R_IDLE) ? (head_len == CW'(1)) : (rem_q == CW'(1));
  assign Rd_En      = issue;
  assign Rd_Addr    = rd_ptr_q[pADDR_W-1:0];
  assign M_Valid    = sk_cnt_q != 2'd0;
  assign M_Data     = sk0_q[7:0];
  assign M_Last     = M_Valid && sk0_q[8];

  always_comb begin
    sk_cnt_d = sk_cnt_q;
    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    if (pop_out) begin
      sk0_d    = sk1_q;
      sk_cnt_d = sk_cnt_q - 2'd1;
    end
    if (infl_q) begin
      if (sk_cnt_d == 2'd0) sk0_d = {infl_last_q, Rd_Data};
      else                  sk1_d = {infl_last_q, Rd_Data};
      sk_cnt_d = sk_cnt_d + 2'd1;
    end
  end

  // The descriptor stays queued until its frame is fully delivered
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rst_q       <= R_IDLE;
      rd_ptr_q    <= '0;
      rem_q       <= '0;
      desc_rp_q   <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      sk_cnt_q    <= '0;
      sk0_q       <= '0;
      sk1_q       <= '0;
    end else begin
      infl_q      <= issue;
      infl_last_q <= issue_last;
      sk_cnt_q    <= sk_cnt_d;
      sk0_q       <= sk0_d;
      sk1_q       <= sk1_d;
      if (issue) rd_ptr_q <= rd_ptr_q + PW'(1);
      case (rst_q)
        R_IDLE: begin
          if (!desc_empty) begin
            rem_q <= head_len - CW'(1);
            rst_q <= R_STREAM;
          end
        end
        default: begin
          if (issue) rem_q <= rem_q - CW'(1);
          if (pop_out && M_Last) begin
            desc_rp_q <= desc_rp_q + (DW+1)'(1);
            rst_q     <= R_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_eth_rx_buf_ctrl.sv
// Scoreboard bench for eth_rx_buf_ctrl: random frame bytes, expected payload queued at
// send time and compared as the output stream delivers it.
`timescale 1ns/1ps
module tb_eth_rx_buf_ctrl;
  localparam int AW = 11;

  logic          Clk = 1'b0;
  logic          Rst, Rx_Byte_Vld, Rx_Eop, Rx_Good, Rx_Bad, M_Ready;
  logic [7:0]    Rx_Byte, Wr_Data, Rd_Data, M_Data;
  logic          Wr_En, Rd_En, M_Valid, M_Last;
  logic [AW-1:0] Wr_Addr, Rd_Addr;
  logic [15:0]   Good_Cnt, Drop_Cnt;

  eth_rx_buf_ctrl #(.pADDR_W(AW)) dut (
    .Clk(Clk), .Rst(Rst), .Rx_Byte_Vld(Rx_Byte_Vld), .Rx_Byte(Rx_Byte), .Rx_Eop(Rx_Eop),
    .Rx_Good(Rx_Good), .Rx_Bad(Rx_Bad), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .M_Data(M_Data), .M_Valid(M_Valid),
    .M_Last(M_Last), .M_Ready(M_Ready), .Good_Cnt(Good_Cnt), .Drop_Cnt(Drop_Cnt)
  );

  always #10 Clk = ~Clk;

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge Clk) begin
    if (Wr_En) mem[Wr_Addr] <= Wr_Data;
    if (Rd_En) Rd_Data <= mem[Rd_Addr];
  end

  int         n_vec = 0;
  int         n_err = 0;
  int         rdy_mode = 1;
  int         exp_good, exp_drop;
  logic [AW:0] exp_commit;
  logic [8:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    M_Ready = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      case (rdy_mode)
        0:       M_Ready = 1'b0;
        1:       M_Ready = 1'b1;
        default: M_Ready = ~M_Ready;
      endcase
    end
  end

  logic       stall = 1'b0;
  logic [8:0] stall_v, exp_b;
  always @(negedge Clk) begin
    if (Rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 32'(M_Valid), 1);
        chk("hold_data", 32'({M_Last, M_Data}), 32'(stall_v));
      end
      if (M_Valid && M_Ready) begin
        if (sb.size() == 0) begin
          chk("out_when_none_expected", 32'(sb.size()), 1);
        end else begin
          exp_b = sb.pop_front();
          chk("out_byte", 32'({M_Last, M_Data}), 32'(exp_b));
        end
      end
      stall   = M_Valid && !M_Ready;
      stall_v = {M_Last, M_Data};
    end
  end

  task automatic do_reset();
    Rst = 1'b1; Rx_Byte_Vld = 1'b0; Rx_Eop = 1'b0; Rx_Good = 1'b0; Rx_Bad = 1'b0;
    Rx_Byte = '0;
    repeat (3) tick();
    Rst = 1'b0;
    sb.delete();
    exp_commit = '0; exp_good = 0; exp_drop = 0;
    chk("rst_wr_en", 32'(Wr_En), 0);
    chk("rst_wr_addr", 32'(Wr_Addr), 0);
    chk("rst_rd_en", 32'(Rd_En), 0);
    chk("rst_m_valid", 32'(M_Valid), 0);
    chk("rst_m_last", 32'(M_Last), 0);
    chk("rst_m_data", 32'(M_Data), 0);
    chk("rst_good_cnt", 32'(Good_Cnt), 0);
    chk("rst_drop_cnt", 32'(Drop_Cnt), 0);
  endtask

  // st: 0 good pulse, 1 bad pulse, 2 no status, 3 good+bad together
  task automatic send_frame(input int len, input int st, input bit good, input bit chk_start);
    logic [7:0]    b;
    logic [AW-1:0] a;
    a = exp_commit[AW-1:0];
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      Rx_Byte_Vld = 1'b1; Rx_Byte = b; Rx_Eop = (i == len - 1);
      if (good && i < len - 4) sb.push_back({1'(i == len - 5), b});
      tick();
      if (i == 0 && chk_start) begin
        chk("first_wr_en", 32'(Wr_En), 1);
        chk("first_wr_addr", 32'(Wr_Addr), 32'(a));
        chk("first_wr_data", 32'(Wr_Data), 32'(b));
      end
    end
    Rx_Byte_Vld = 1'b0; Rx_Eop = 1'b0;
    tick(); tick();
    Rx_Good = (st == 0 || st == 3);
    Rx_Bad  = (st == 1 || st == 3);
    tick();
    Rx_Good = 1'b0; Rx_Bad = 1'b0;
    if (good) begin
      exp_commit = exp_commit + (AW+1)'(len - 4);
      exp_good++;
    end else begin
      exp_drop++;
    end
    repeat ((st == 2) ? 12 : 3) tick();
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((sb.size() != 0 || M_Valid) && c < maxc) begin
      tick();
      c++;
    end
    chk("drain_remaining", 32'(sb.size()), 0);
    chk("drain_m_valid", 32'(M_Valid), 0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_good_cnt"}, 32'(Good_Cnt), 32'(exp_good));
    chk({tag, "_drop_cnt"}, 32'(Drop_Cnt), 32'(exp_drop));
    chk({tag, "_commit_ptr"}, 32'(dut.commit_ptr_q), 32'(exp_commit));
    chk({tag, "_wr_ptr"}, 32'(dut.wr_ptr_q), 32'(exp_commit));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // minimum good frame, continuous ready
    do_reset();
    rdy_mode = 1;
    send_frame(64, 0, 1, 1);
    drain(300);
    chk_counts("min_good");

    // bad frame rewinds; next good frame reuses address 0
    do_reset();
    send_frame(100, 1, 0, 1);
    send_frame(70, 0, 1, 1);
    drain(300);
    chk_counts("bad_then_good");

    // runt, giant, simultaneous good+bad, then a maximum-size good frame
    do_reset();
    send_frame(40, 0, 0, 1);
    send_frame(1519, 0, 0, 1);
    send_frame(80, 3, 0, 1);
    send_frame(1518, 0, 1, 1);
    drain(2000);
    chk_counts("size_limits");

    // buffer overflow with stalled consumer, then a frame straddling the wrap
    do_reset();
    rdy_mode = 0;
    send_frame(1500, 0, 1, 1);
    send_frame(600, 0, 0, 1);
    chk_counts("overflow");
    rdy_mode = 1;
    drain(3000);
    send_frame(600, 0, 1, 1);
    drain(1000);
    chk_counts("wrap");

    // descriptor FIFO full: fifth frame dropped
    do_reset();
    rdy_mode = 0;
    for (int f = 0; f < 5; f++) send_frame(64, 0, f < 4, f < 4);
    chk_counts("desc_full");
    rdy_mode = 1;
    drain(1000);
    chk_counts("desc_drain");

    // reset while an output frame is stalled mid-stream
    rdy_mode = 0;
    send_frame(64, 0, 1, 1);
    chk("pre_abort_valid", 32'(M_Valid), 1);
    do_reset();

    // toggling ready, then a status timeout
    rdy_mode = 2;
    send_frame(64, 0, 1, 1);
    drain(500);
    send_frame(64, 2, 0, 1);
    drain(50);
    chk_counts("toggle_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
